// File: rtl/regfile_scoreboard.sv
// Integer register file with two read ports, a single-cycle writeback port, a
// long-latency completion port and a busy-bit scoreboard for in-flight results.
module regfile_scoreboard #(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wa_en,
    input  logic [AW-1:0]   wa_addr,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    output logic [AW:0]     busy_count,
    output logic            sb_err
);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [AW:0]         busy_count_q, busy_count_d;
    logic                sb_err_q, sb_err_d;

    logic wa_hit, wb_hit, iss_hit;

    assign wa_hit  = wa_en  && (wa_addr  != '0);
    assign wb_hit  = wb_en  && (wb_addr  != '0);
    assign iss_hit = iss_en && (iss_addr != '0);

    always_comb begin
        regs_d   = regs_q;
        busy_d   = busy_q;
        sb_err_d = sb_err_q;
        if (wa_hit) begin
            regs_d[wa_addr] = wa_data;
        end
        // Port B is applied after port A so its data wins on an address clash.
        if (wb_hit) begin
            regs_d[wb_addr] = wb_data;
            busy_d[wb_addr] = 1'b0;
            if (!busy_q[wb_addr]) begin
                sb_err_d = 1'b1;
            end
        end
        // A new issue overrides a same-cycle completion of the same register.
        if (iss_hit) begin
            busy_d[iss_addr] = 1'b1;
            if (busy_q[iss_addr] && !(wb_hit && (wb_addr == iss_addr))) begin
                sb_err_d = 1'b1;
            end
        end
        busy_count_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_count_d = busy_count_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
            sb_err_q     <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            sb_err_q     <= sb_err_d;
        end
    end

    // Register 0 is never written nor marked busy, so plain lookups read 0/idle.
    always_comb begin
        rs1_data = regs_q[rs1_addr];
        rs1_busy = busy_q[rs1_addr];
        if (BYPASS != 0) begin
            if (wa_hit && (wa_addr == rs1_addr)) begin
                rs1_data = wa_data;
            end
            if (wb_hit && (wb_addr == rs1_addr)) begin
                rs1_data = wb_data;
                if (!(iss_hit && (iss_addr == rs1_addr))) begin
                    rs1_busy = 1'b0;
                end
            end
        end
    end

    always_comb begin
        rs2_data = regs_q[rs2_addr];
        rs2_busy = busy_q[rs2_addr];
        if (BYPASS != 0) begin
            if (wa_hit && (wa_addr == rs2_addr)) begin
                rs2_data = wa_data;
            end
            if (wb_hit && (wb_addr == rs2_addr)) begin
                rs2_data = wb_data;
                if (!(iss_hit && (iss_addr == rs2_addr))) begin
                    rs2_busy = 1'b0;
                end
            end
        end
    end

    assign busy_count = busy_count_q;
    assign sb_err     = sb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: a forwarding instance and a
// non-forwarding instance share all inputs; expectations flow through exp_q.
module tb_regfile_scoreboard;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic            clk;
    logic            reset;
    logic [AW-1:0]   rs1_addr, rs2_addr;
    logic            wa_en, wb_en, iss_en;
    logic [AW-1:0]   wa_addr, wb_addr, iss_addr;
    logic [XLEN-1:0] wa_data, wb_data;

    logic [XLEN-1:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
    logic            rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;
    logic [AW:0]     busy_count, nb_busy_count;
    logic            sb_err, nb_sb_err;

    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] exp;
    int              n_cmp;
    int              n_err;

    regfile_scoreboard dut (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_count(busy_count), .sb_err(sb_err)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
        .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_count(nb_busy_count), .sb_err(nb_sb_err)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks: inputs change 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        wa_en  = 1'b0;
        wb_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic drive_wa(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wa_en = 1'b1; wa_addr = a; wa_data = d;
    endtask

    task automatic drive_wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
    endtask

    task automatic drive_iss(input logic [AW-1:0] a);
        iss_en = 1'b1; iss_addr = a;
    endtask

    task automatic test_reset();
        do_reset();
        rs1_addr = 5'd5; rs2_addr = 5'd31;
        exp_q.push_back('0);
        exp_q.push_back('0);
        exp_q.push_back('0);
        exp_q.push_back('0);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (rs1_data !== exp) begin n_err++; $display("FAIL reset_rs1_data: got %h exp %h", rs1_data, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (XLEN'(rs2_busy) !== exp) begin n_err++; $display("FAIL reset_rs2_busy: got %0d exp %0d", rs2_busy, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (XLEN'(busy_count) !== exp) begin n_err++; $display("FAIL reset_busy_count: got %0d exp %0d", busy_count, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (XLEN'(sb_err) !== exp) begin n_err++; $display("FAIL reset_sb_err: got %0d exp %0d", sb_err, exp); end
    endtask

    task automatic test_basic_write();
        do_reset();
        drive_wa(5'd5, 64'hDEAD_BEEF);
        exp_q.push_back(64'hDEAD_BEEF);
        exp_q.push_back(64'h0);
        step();
        rs1_addr = 5'd5;
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (rs1_data !== exp) begin n_err++; $display("FAIL basic_rs1_data: got %h exp %h", rs1_data, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (XLEN'(rs1_busy) !== exp) begin n_err++; $display("FAIL basic_rs1_busy: got %0d exp %0d", rs1_busy, exp); end
        drive_wa(5'd0, 64'h1234);
        drive_iss(5'd0);
        rs1_addr = 5'd0;
        exp_q.push_back(64'h0);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (rs1_data !== exp) begin n_err++; $display("FAIL x0_bypass: got %h exp %h", rs1_data, exp); end
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        step();
        exp = exp_q.pop_front(); n_cmp++;
        if (rs1_data !== exp) begin n_err++; $display("FAIL x0_read: got %h exp %h", rs1_data, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (XLEN'(sb_err) !== exp) begin n_err++; $display("FAIL x0_sb_err: got %0d exp %0d", sb_err, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (XLEN'(busy_count) !== exp) begin n_err++; $display("FAIL x0_busy_count: got %0d exp %0d", busy_count, exp); end
    endtask

    task automatic test_issue_complete();
        do_reset();
        drive_iss(5'd7);
        step();
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL iss_busy: got %0d exp 1", rs1_busy); end
        n_cmp++;
        if (busy_count !== 6'd1) begin n_err++; $display("FAIL iss_busy_count: got %0d exp 1", busy_count); end
        drive_wb(5'd7, 64'h55);
        exp_q.push_back(64'h55);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h1);
        #1;
        exp = exp_q.pop_front(); n_cmp++;
        if (rs1_data !== exp) begin n_err++; $display("FAIL wb_bypass_data: got %h exp %h", rs1_data, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (XLEN'(rs2_busy) !== exp) begin n_err++; $display("FAIL wb_bypass_busy: got %0d exp %0d", rs2_busy, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (nb_rs1_data !== exp) begin n_err++; $display("FAIL nb_wb_data: got %h exp %h", nb_rs1_data, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (XLEN'(nb_rs1_busy) !== exp) begin n_err++; $display("FAIL nb_wb_busy: got %0d exp %0d", nb_rs1_busy, exp); end
        step();
        n_cmp++;
        if (busy_count !== 6'd0) begin n_err++; $display("FAIL wb_busy_count: got %0d exp 0", busy_count); end
        n_cmp++;
        if (sb_err !== 1'b0) begin n_err++; $display("FAIL wb_sb_err: got %0d exp 0", sb_err); end
        n_cmp++;
        if (nb_rs1_data !== 64'h55) begin n_err++; $display("FAIL nb_wb_commit: got %h exp 55", nb_rs1_data); end
    endtask

    task automatic test_dual_write();
        do_reset();
        drive_wa(5'd3, 64'h11);
        drive_wb(5'd3, 64'h22);
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        #1;
        n_cmp++;
        if (rs1_data !== 64'h22 || rs2_data !== 64'h22) begin
            n_err++; $display("FAIL dual_bypass: got %h/%h exp 22", rs1_data, rs2_data);
        end
        n_cmp++;
        if (nb_rs2_data !== 64'h0) begin n_err++; $display("FAIL nb_dual_prior: got %h exp 0", nb_rs2_data); end
        step();
        n_cmp++;
        if (rs1_data !== 64'h22 || nb_rs1_data !== 64'h22) begin
            n_err++; $display("FAIL dual_commit: got %h/%h exp 22", rs1_data, nb_rs1_data);
        end
        n_cmp++;
        if (sb_err !== 1'b1) begin n_err++; $display("FAIL wb_idle_err: got %0d exp 1", sb_err); end
        drive_wa(5'd3, 64'h33);
        #1;
        n_cmp++;
        if (rs1_data !== 64'h33 || nb_rs1_data !== 64'h22) begin
            n_err++; $display("FAIL wa_bypass: got %h/%h exp 33/22", rs1_data, nb_rs1_data);
        end
        step();
    endtask

    task automatic test_double_issue();
        do_reset();
        drive_iss(5'd9);
        step();
        n_cmp++;
        if (sb_err !== 1'b0) begin n_err++; $display("FAIL first_iss_err: got %0d exp 0", sb_err); end
        drive_iss(5'd9);
        step();
        n_cmp++;
        if (sb_err !== 1'b1) begin n_err++; $display("FAIL double_iss_err: got %0d exp 1", sb_err); end
        n_cmp++;
        if (busy_count !== 6'd1) begin n_err++; $display("FAIL double_iss_count: got %0d exp 1", busy_count); end
        drive_wb(5'd10, 64'hAB);
        step();
        rs1_addr = 5'd10; rs2_addr = 5'd9;
        #1;
        n_cmp++;
        if (sb_err !== 1'b1 || rs1_data !== 64'hAB) begin
            n_err++; $display("FAIL idle_wb: got err %0d data %h exp 1/ab", sb_err, rs1_data);
        end
        n_cmp++;
        if (rs2_busy !== 1'b1 || busy_count !== 6'd1) begin
            n_err++; $display("FAIL idle_wb_busy: got %0d/%0d exp 1/1", rs2_busy, busy_count);
        end
    endtask

    task automatic test_iss_wb_same();
        do_reset();
        drive_iss(5'd4);
        step();
        drive_iss(5'd4);
        drive_wb(5'd4, 64'h77);
        rs1_addr = 5'd4; rs2_addr = 5'd4;
        #1;
        n_cmp++;
        if (rs1_data !== 64'h77 || rs1_busy !== 1'b1) begin
            n_err++; $display("FAIL iss_wb_bypass: got %h/%0d exp 77/1", rs1_data, rs1_busy);
        end
        step();
        n_cmp++;
        if (rs2_data !== 64'h77 || rs2_busy !== 1'b1) begin
            n_err++; $display("FAIL iss_wb_commit: got %h/%0d exp 77/1", rs2_data, rs2_busy);
        end
        n_cmp++;
        if (sb_err !== 1'b0 || busy_count !== 6'd1) begin
            n_err++; $display("FAIL iss_wb_status: got err %0d cnt %0d exp 0/1", sb_err, busy_count);
        end
    endtask

    task automatic test_fill_and_reset();
        do_reset();
        for (int i = 1; i < 32; i++) begin
            drive_iss(AW'(i));
            exp_q.push_back(XLEN'(i));
            step();
            exp = exp_q.pop_front(); n_cmp++;
            if (XLEN'(busy_count) !== exp) begin n_err++; $display("FAIL fill_count: got %0d exp %0d", busy_count, exp); end
        end
        n_cmp++;
        if (sb_err !== 1'b0) begin n_err++; $display("FAIL fill_sb_err: got %0d exp 0", sb_err); end
        reset = 1'b1;
        drive_wa(5'd5, 64'hF00D);
        drive_wb(5'd6, 64'hBEEF);
        drive_iss(5'd2);
        step();
        reset = 1'b0;
        n_cmp++;
        if (busy_count !== 6'd0 || sb_err !== 1'b0) begin
            n_err++; $display("FAIL rst_status: got cnt %0d err %0d exp 0/0", busy_count, sb_err);
        end
        for (int a = 0; a < 32; a++) begin
            rs1_addr = AW'(a); rs2_addr = AW'(31 - a);
            #1;
            n_cmp++;
            if (rs1_data !== '0 || rs1_busy !== 1'b0 || rs2_data !== '0 || rs2_busy !== 1'b0) begin
                n_err++; $display("FAIL rst_reg x%0d: got %h/%0d exp 0/0", a, rs1_data, rs1_busy);
            end
        end
        drive_wb(5'd6, 64'h1);
        step();
        n_cmp++;
        if (sb_err !== 1'b1) begin n_err++; $display("FAIL post_rst_wb_err: got %0d exp 1", sb_err); end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] mdl [32];
        logic [AW-1:0]   a, b;
        logic [XLEN-1:0] d;
        do_reset();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        for (int k = 0; k < 40; k++) begin
            a = AW'($urandom_range(0, 31));
            d = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) drive_wa(a, d);
            else drive_wb(a, d);
            if (a != '0) mdl[a] = d;
            b = AW'($urandom_range(0, 31));
            exp_q.push_back(mdl[a]);
            exp_q.push_back(mdl[b]);
            step();
            rs1_addr = a; rs2_addr = b;
            #1;
            exp = exp_q.pop_front(); n_cmp++;
            if (rs1_data !== exp) begin n_err++; $display("FAIL b2b_rs1 x%0d: got %h exp %h", a, rs1_data, exp); end
            exp = exp_q.pop_front(); n_cmp++;
            if (nb_rs2_data !== exp) begin n_err++; $display("FAIL b2b_rs2 x%0d: got %h exp %h", b, nb_rs2_data, exp); end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b0;
        rs1_addr = '0; rs2_addr = '0;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        iss_en = 1'b0; iss_addr = '0;
        test_reset();
        test_basic_write();
        test_issue_complete();
        test_dual_write();
        test_double_issue();
        test_iss_wb_same();
        test_fill_and_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
